// File: rtl/ro_freq_meter.sv
// ============================================================================
//  Module   : ro_freq_meter
//  Purpose  : Ring-oscillator frequency meter. Enables the oscillator, lets it
//             settle, then counts rising ro_in edges over a window of
//             2^WIN_LOG2 clk cycles and reports the total.
//  Ports    : clk         - system clock
//             rst_n       - asynchronous reset, ACTIVE-HIGH despite its name
//             start       - one-cycle measurement request (ignored while busy)
//             ro_in       - oscillator output, asynchronous to clk
//             ro_activate - registered enable for the oscillator
//             busy        - high whenever the FSM is not idle
//             done        - one-cycle pulse, count/overflow valid
//             count       - rising edges counted in the last window
//             overflow    - last total did not fit in CNT_W bits
//  Config   : RO_FREQ_SAT_EN defined   -> count saturates, overflow reported
//             RO_FREQ_SAT_EN undefined -> count wraps, overflow tied low
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ro_freq_meter #(
  parameter int WIN_LOG2 = 10,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ro_in,
  output logic             ro_activate,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int c_TMR_W = (WIN_LOG2 > 2) ? WIN_LOG2 : 2;
  localparam logic [c_TMR_W-1:0] c_WARM_LAST = c_TMR_W'(3);
  localparam logic [c_TMR_W-1:0] c_MEAS_LAST = c_TMR_W'((64'd1 << WIN_LOG2) - 64'd1);

`ifdef RO_FREQ_SAT_EN
  // Bit CNT_W is a sticky "total exceeded the count range" flag.
  localparam int c_ACC_W = CNT_W + 1;
`else
  localparam int c_ACC_W = CNT_W;
`endif

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_WARMUP  = 3'd1;
  localparam logic [2:0] c_SNAP    = 3'd2;
  localparam logic [2:0] c_MEASURE = 3'd3;
  localparam logic [2:0] c_DONE    = 3'd4;

  // --------------------------------------------------------------------------
  // ro_in domain: free-running 8-bit counter, published in Gray code so that
  // only one bit changes per edge and the clk-side sample is never torn.
  // --------------------------------------------------------------------------
  logic [7:0] r_ro_bin;
  logic [7:0] r_ro_gray;
  logic [7:0] w_ro_bin_nxt;
  logic       r_ro_act;

  assign w_ro_bin_nxt = r_ro_bin + 8'd1;

  always_ff @(posedge ro_in or posedge rst_n) begin
    if (rst_n) begin
      r_ro_bin  <= 8'd0;
      r_ro_gray <= 8'd0;
    end else if (r_ro_act) begin
      r_ro_bin  <= w_ro_bin_nxt;
      r_ro_gray <= w_ro_bin_nxt ^ (w_ro_bin_nxt >> 1);
    end
  end

  // --------------------------------------------------------------------------
  // clk domain: two-flop synchronizer per bit, then Gray -> binary.
  // --------------------------------------------------------------------------
  logic [7:0] r_sync1;
  logic [7:0] r_sync2;
  logic [7:0] w_cur_bin;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_sync1 <= 8'd0;
      r_sync2 <= 8'd0;
    end else begin
      r_sync1 <= r_ro_gray;
      r_sync2 <= r_sync1;
    end
  end

  // Binary bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    w_cur_bin = 8'd0;
    for (int i = 0; i < 8; i++) begin
      w_cur_bin[i] = ^(r_sync2 >> i);
    end
  end

  // --------------------------------------------------------------------------
  // Accumulation of per-cycle deltas (mod 256 handles counter wrap).
  // --------------------------------------------------------------------------
  logic [2:0]         r_state;
  logic [c_TMR_W-1:0] r_tmr;
  logic [7:0]         r_prev;
  logic [c_ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]   r_count;
  logic [7:0]         w_delta;
  logic [c_ACC_W-1:0] w_acc_nxt;
  logic [CNT_W-1:0]   w_res_cnt;

  assign w_delta = w_cur_bin - r_prev;

`ifdef RO_FREQ_SAT_EN
  logic               r_ovf;
  logic [c_ACC_W-1:0] w_sum;

  // Once the flag bit is set the accumulator is clamped to exactly 2^CNT_W,
  // so adding at most 255 can never carry past the flag (CNT_W >= 8).
  assign w_sum     = r_acc + c_ACC_W'(w_delta);
  assign w_acc_nxt = w_sum[CNT_W] ? {1'b1, {CNT_W{1'b0}}} : w_sum;
  assign w_res_cnt = w_acc_nxt[CNT_W] ? {CNT_W{1'b1}} : w_acc_nxt[CNT_W-1:0];
  assign overflow  = r_ovf;
`else
  assign w_acc_nxt = r_acc + c_ACC_W'(w_delta);
  assign w_res_cnt = w_acc_nxt;
  assign overflow  = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Sequencer. The final MEASURE add is folded straight into the result so
  // count is already valid in the cycle done is high.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state  <= c_IDLE;
      r_tmr    <= '0;
      r_ro_act <= 1'b0;
      r_prev   <= 8'd0;
      r_acc    <= '0;
      r_count  <= '0;
`ifdef RO_FREQ_SAT_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_state  <= c_WARMUP;
            r_tmr    <= '0;
            r_ro_act <= 1'b1;
          end
        end
        c_WARMUP: begin
          if (r_tmr == c_WARM_LAST) begin
            r_state <= c_SNAP;
          end else begin
            r_tmr <= r_tmr + c_TMR_W'(1);
          end
        end
        c_SNAP: begin
          r_prev  <= w_cur_bin;
          r_acc   <= '0;
          r_tmr   <= '0;
          r_state <= c_MEASURE;
        end
        c_MEASURE: begin
          r_prev <= w_cur_bin;
          r_acc  <= w_acc_nxt;
          if (r_tmr == c_MEAS_LAST) begin
            r_state  <= c_DONE;
            r_ro_act <= 1'b0;
            r_count  <= w_res_cnt;
`ifdef RO_FREQ_SAT_EN
            r_ovf    <= w_acc_nxt[CNT_W];
`endif
          end else begin
            r_tmr <= r_tmr + c_TMR_W'(1);
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state  <= c_IDLE;
          r_ro_act <= 1'b0;
        end
      endcase
    end
  end

  assign ro_activate = r_ro_act;
  assign busy        = (r_state != c_IDLE);
  assign done        = (r_state == c_DONE);
  assign count       = r_count;

endmodule

`default_nettype wire

// File: tb/tb_ro_freq_meter.sv
// ============================================================================
//  Module   : tb_ro_freq_meter
//  Purpose  : Self-checking bench for ro_freq_meter (WIN_LOG2=4, CNT_W=8).
//             The reference model predicts the result as the number of
//             oscillator edges that fit in a 16 x 10 ns window (+/-1 for
//             phase), folded by saturation or wrap depending on
//             RO_FREQ_SAT_EN, and predicts busy/done/ro_activate from the
//             cycle index since start was accepted.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ro_freq_meter;

  localparam int WIN_LOG2 = 4;
  localparam int CNT_W    = 8;
  localparam int N        = 16;
  localparam int LAT      = N + 6;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             ro_in;
  logic             ro_activate;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic             overflow;

  int ro_half_ps;
  int n_cmp;
  int n_fail;

  ro_freq_meter #(.WIN_LOG2(WIN_LOG2), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .ro_in       (ro_in),
    .ro_activate (ro_activate),
    .busy        (busy),
    .done        (done),
    .count       (count),
    .overflow    (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Oscillator: half period in ps, 0 means stopped (held low).
  initial begin
    ro_in = 1'b0;
    #0.3;
    forever begin
      if (ro_half_ps == 0) begin
        ro_in = 1'b0;
        #0.1;
      end else begin
        #(ro_half_ps / 1000.0);
        ro_in = ~ro_in;
      end
    end
  end

  task automatic chk(input string name, input bit ok, input longint act, input longint req);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected rising edges within the measurement window.
  function automatic real exp_edges(input int half_ps);
    if (half_ps == 0) return 0.0;
    return (N * 10000.0) / (2.0 * half_ps);
  endfunction

  function automatic bit result_ok(input real e, input logic [CNT_W-1:0] c, input logic o);
    real d;
    d = real'(c) - e;
`ifdef RO_FREQ_SAT_EN
    if (e >= 256.0) return (c == 8'hFF) && o;
    return !o && (d <= 1.0) && (d >= -1.0);
`else
    while (d > 128.0)  d = d - 256.0;
    while (d < -128.0) d = d + 256.0;
    return !o && (d <= 1.0) && (d >= -1.0);
`endif
  endfunction

  // ---------------- reference model ----------------
  int  m_t;       // -1 idle, else cycle index since start was accepted
  real m_e;
  real m_last_e;
  bit  m_have;

  initial begin
    m_t      = -1;
    m_e      = 0.0;
    m_last_e = 0.0;
    m_have   = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      m_t    = -1;
      m_have = 1'b0;
    end else if (m_t < 0) begin
      if (start) begin
        m_t = 1;
        m_e = exp_edges(ro_half_ps);
      end
    end else if (m_t == LAT) begin
      m_t      = -1;
      m_have   = 1'b1;
      m_last_e = m_e;
    end else begin
      m_t = m_t + 1;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("reset_outputs", {ro_activate, busy, done, overflow} == 4'b0 && count == '0,
          {ro_activate, busy, done, overflow, count}, 0);
    end else begin
      chk("busy", busy == (m_t >= 1), busy, m_t >= 1);
      chk("done", done == (m_t == LAT), done, m_t == LAT);
      chk("ro_activate", ro_activate == (m_t >= 1 && m_t < LAT), ro_activate,
          m_t >= 1 && m_t < LAT);
      if (m_t == LAT)
        chk("result", result_ok(m_e, count, overflow), {overflow, count}, longint'(m_e));
      else if (m_have)
        chk("hold", result_ok(m_last_e, count, overflow), {overflow, count}, longint'(m_last_e));
      else
        chk("cleared", count == '0 && !overflow, {overflow, count}, 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic measure(input int half_ps, input bit inject,
                         output int lat, output logic [CNT_W-1:0] c, output logic o);
    ro_half_ps = half_ps;
    repeat (3) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    lat = -1;
    c   = '0;
    o   = 1'b0;
    for (int i = 1; i <= LAT + 20; i++) begin
      @(negedge clk);
      start = (inject && i == 10);
      if (done) begin
        lat = i;
        c   = count;
        o   = overflow;
        break;
      end
    end
    start = 1'b0;
    chk("latency", lat == LAT, lat, LAT);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int               lat;
    logic [CNT_W-1:0] c;
    logic             o;
    int               h;
    n_cmp      = 0;
    n_fail     = 0;
    ro_half_ps = 0;
    rst_n      = 1'b1;
    start      = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;

    // 2.5 ns oscillator: 64 edges per window.
    measure(1250, 1'b0, lat, c, o);
    chk("lit_4x_count", c >= 8'd63 && c <= 8'd65, c, 64);
    chk("lit_4x_ovf", o == 1'b0, o, 0);

    // Stopped oscillator.
    measure(0, 1'b0, lat, c, o);
    chk("lit_stopped", c == 8'd0 && o == 1'b0, {o, c}, 0);

    // ~32x clk: ~512 edges.
    measure(156, 1'b0, lat, c, o);
`ifdef RO_FREQ_SAT_EN
    chk("lit_32x_sat", c == 8'd255 && o == 1'b1, {o, c}, 511);
`else
    chk("lit_32x_wrap", (c <= 8'd1 || c == 8'd255) && o == 1'b0, {o, c}, 0);
`endif

    // start during MEASURE must be ignored.
    measure(1250, 1'b1, lat, c, o);
    chk("lit_inject_count", c >= 8'd63 && c <= 8'd65, c, 64);

    // Random oscillator rates, avoiding the ambiguous band around 2^CNT_W.
    for (int k = 0; k < 6; k++) begin
      h = $urandom_range(10000, 80);
      while (exp_edges(h) >= 250.0 && exp_edges(h) <= 262.0) h = $urandom_range(10000, 80);
      measure(h, 1'b0, lat, c, o);
    end

    // Abort in MEASURE with reset.
    ro_half_ps = 1250;
    repeat (3) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (12) @(negedge clk);
    #1 rst_n = 1'b1;
    #1 chk("abort_immediate", {ro_activate, busy, done, overflow} == 4'b0 && count == '0,
           {ro_activate, busy, done, overflow, count}, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    measure(1250, 1'b0, lat, c, o);
    chk("lit_after_abort", c >= 8'd63 && c <= 8'd65 && o == 1'b0, {o, c}, 64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
